// File: rtl/mem_arbiter.sv
// Memory arbiter: grants the byte-serial memory unit to instruction fetch or
// load/store, round-robin on contention, with flush and UART-stall handling.
module mem_arbiter #(
   parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear_in,
   input  logic        io_buffer_full,
   input  logic        if_valid,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_data,
   input  logic        ls_valid,
   input  logic        ls_wr,
   input  logic [31:0] ls_addr,
   input  logic [2:0]  ls_len,
   input  logic [31:0] ls_wdata,
   output logic        ls_ready,
   output logic [31:0] ls_rdata,
   output logic        mu_valid,
   output logic        mu_wr,
   output logic [31:0] mu_addr,
   output logic [2:0]  mu_len,
   output logic [31:0] mu_data_in,
   input  logic [31:0] mu_data_out,
   input  logic        mu_ready
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,
      BUSY_LS
   } state_e;

   state_e      state_q, state_d;
   logic        last_ls_q, last_ls_d;
   logic        drop_q, drop_d;
   logic        mu_valid_q, mu_valid_d;
   logic        mu_wr_q, mu_wr_d;
   logic [31:0] mu_addr_q, mu_addr_d;
   logic [2:0]  mu_len_q, mu_len_d;
   logic [31:0] mu_data_in_q, mu_data_in_d;
   logic        if_ready_q, if_ready_d;
   logic [31:0] if_data_q, if_data_d;
   logic        ls_ready_q, ls_ready_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;

   logic if_elig;
   logic ls_elig;
   logic ls_io_stall;
   logic grant_if;
   logic grant_ls;
   logic kill;

   // A client still showing its ready pulse holds a stale valid
   always_comb begin
      ls_io_stall = ls_wr & io_buffer_full
                  & (ls_addr[17:16] == IO_ADDR_HI);
      if_elig  = if_valid & ~if_ready_q & ~clear_in;
      ls_elig  = ls_valid & ~ls_ready_q & ~ls_io_stall;
      grant_ls = ls_elig & (~if_elig | ~last_ls_q);
      grant_if = if_elig & (~ls_elig | last_ls_q);
      kill     = drop_q | clear_in;
   end

   always_comb begin
      state_d      = state_q;
      last_ls_d    = last_ls_q;
      drop_d       = drop_q;
      mu_valid_d   = mu_valid_q;
      mu_wr_d      = mu_wr_q;
      mu_addr_d    = mu_addr_q;
      mu_len_d     = mu_len_q;
      mu_data_in_d = mu_data_in_q;
      if_ready_d   = 1'b0;
      if_data_d    = if_data_q;
      ls_ready_d   = 1'b0;
      ls_rdata_d   = ls_rdata_q;
      unique case (state_q)
         IDLE: begin
            drop_d = clear_in;
            if (grant_ls) begin
               state_d      = BUSY_LS;
               last_ls_d    = 1'b1;
               mu_valid_d   = 1'b1;
               mu_wr_d      = ls_wr;
               mu_addr_d    = ls_addr;
               mu_len_d     = ls_len;
               mu_data_in_d = ls_wdata;
            end else if (grant_if) begin
               state_d      = BUSY_IF;
               last_ls_d    = 1'b0;
               mu_valid_d   = 1'b1;
               mu_wr_d      = 1'b0;
               mu_addr_d    = if_addr;
               mu_len_d     = 3'b010;
               mu_data_in_d = 32'h0;
            end
         end
         BUSY_IF: begin
            drop_d = kill;
            if (mu_ready) begin
               state_d    = IDLE;
               drop_d     = 1'b0;
               mu_valid_d = 1'b0;
               if_data_d  = mu_data_out;
               if_ready_d = ~kill;
            end
         end
         BUSY_LS: begin
            drop_d = kill;
            if (mu_ready) begin
               state_d    = IDLE;
               drop_d     = 1'b0;
               mu_valid_d = 1'b0;
               ls_rdata_d = mu_data_out;
               // Stores have already been committed; never lose their ack
               ls_ready_d = mu_wr_q | ~kill;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         last_ls_q    <= 1'b0;
         drop_q       <= 1'b0;
         mu_valid_q   <= 1'b0;
         mu_wr_q      <= 1'b0;
         mu_addr_q    <= 32'h0;
         mu_len_q     <= 3'b000;
         mu_data_in_q <= 32'h0;
         if_ready_q   <= 1'b0;
         if_data_q    <= 32'h0;
         ls_ready_q   <= 1'b0;
         ls_rdata_q   <= 32'h0;
      end else if (rdy_in) begin
         state_q      <= state_d;
         last_ls_q    <= last_ls_d;
         drop_q       <= drop_d;
         mu_valid_q   <= mu_valid_d;
         mu_wr_q      <= mu_wr_d;
         mu_addr_q    <= mu_addr_d;
         mu_len_q     <= mu_len_d;
         mu_data_in_q <= mu_data_in_d;
         if_ready_q   <= if_ready_d;
         if_data_q    <= if_data_d;
         ls_ready_q   <= ls_ready_d;
         ls_rdata_q   <= ls_rdata_d;
      end
   end

   assign mu_valid   = mu_valid_q;
   assign mu_wr      = mu_wr_q;
   assign mu_addr    = mu_addr_q;
   assign mu_len     = mu_len_q;
   assign mu_data_in = mu_data_in_q;
   assign if_ready   = if_ready_q;
   assign if_data    = if_data_q;
   assign ls_ready   = ls_ready_q;
   assign ls_rdata   = ls_rdata_q;

endmodule
